// File: rtl/forward_scoreboard_pkg.sv
// Shared types and decode latency constants for the forwarding scoreboard.
// The optional FORWARD_SCOREBOARD_JB_EARLY_EN build only affects the top module.
package fwd_pkg;

   localparam int FWD_REG_W = 5;
   localparam int FWD_LAT_W = 3;
   localparam int NUM_REGS  = 2 ** FWD_REG_W;

   typedef logic [FWD_LAT_W-1:0] lat_t;
   typedef logic [FWD_REG_W-1:0] regf_t;

   // Issue latencies used by decode: cycles a result is on no bus after issue.
   localparam lat_t LAT_ALU    = lat_t'(0);
   localparam lat_t LAT_LOAD   = lat_t'(1);
   localparam lat_t LAT_MULDIV = lat_t'(5);

endpackage

// File: rtl/forward_scoreboard_mux.sv
// Three-source priority forward select for one ID read port (EX > MM > WB).
module fwd_mux #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic [REG_W-1:0]  rd_regf,
   input  logic [REG_W-1:0]  from_ex_regf,
   input  logic [REG_W-1:0]  from_mm_regf,
   input  logic [REG_W-1:0]  from_wb_regf,
   input  logic [DATA_W-1:0] from_ex_data,
   input  logic [DATA_W-1:0] from_mm_data,
   input  logic [DATA_W-1:0] from_wb_data,
   output logic              fwd_valid,
   output logic [DATA_W-1:0] fwd_data
);

   always_comb begin
      fwd_valid = 1'b0;
      fwd_data  = '0;
      if (rd_regf != '0) begin
         if (rd_regf == from_ex_regf) begin
            fwd_valid = 1'b1;
            fwd_data  = from_ex_data;
         end else if (rd_regf == from_mm_regf) begin
            fwd_valid = 1'b1;
            fwd_data  = from_mm_data;
         end else if (rd_regf == from_wb_regf) begin
            fwd_valid = 1'b1;
            fwd_data  = from_wb_data;
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Per-register latency scoreboard with priority forwarding and ID stall.
// Define FORWARD_SCOREBOARD_JB_EARLY_EN to stall ID branches on EX/MM matches.
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = FWD_REG_W,
   parameter int NRD    = 2,
   parameter int LAT_W  = FWD_LAT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  issue_valid,
   input  logic [REG_W-1:0]      issue_regf,
   input  logic [LAT_W-1:0]      issue_lat,
   input  logic [REG_W-1:0]      from_ex_regf,
   input  logic [REG_W-1:0]      from_mm_regf,
   input  logic [REG_W-1:0]      from_wb_regf,
   input  logic [DATA_W-1:0]     from_ex_data,
   input  logic [DATA_W-1:0]     from_mm_data,
   input  logic [DATA_W-1:0]     from_wb_data,
   input  logic [NRD*REG_W-1:0]  rd_regf,
   input  logic                  rd_jb,
   output logic [NRD-1:0]        fwd_valid,
   output logic [NRD*DATA_W-1:0] fwd_data,
   output logic                  stall,
   output logic [2**REG_W-1:0]   pending
);

   localparam int NREG = 2 ** REG_W;

   logic [LAT_W-1:0] cnt [NREG];
   logic [NRD-1:0]   port_busy;
   logic [NRD-1:0]   port_jb_hit;
   logic [REG_W-1:0] rs;
   logic             accept;

   always_comb begin
      port_busy   = '0;
      port_jb_hit = '0;
      rs          = '0;
      for (int p = 0; p < NRD; p++) begin
         rs           = rd_regf[p*REG_W +: REG_W];
         port_busy[p] = (rs != '0) && (cnt[rs] != '0);
`ifdef FORWARD_SCOREBOARD_JB_EARLY_EN
         port_jb_hit[p] = rd_jb && (rs != '0) &&
                          ((rs == from_ex_regf) || (rs == from_mm_regf));
`endif
      end
   end

`ifndef FORWARD_SCOREBOARD_JB_EARLY_EN
   logic unused_jb;
   assign unused_jb = rd_jb;
`endif

   assign stall  = (|port_busy) | (|port_jb_hit);
   assign accept = issue_valid & ~stall & ~hold & ~flush & (issue_regf != '0);

   // Issue to a register overrides that register's decrement in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else if (!hold) begin
         for (int r = 0; r < NREG; r++) begin
            if (r == 0)
               cnt[r] <= '0;
            else if (accept && (issue_regf == REG_W'(r)))
               cnt[r] <= issue_lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int r = 1; r < NREG; r++) pending[r] = (cnt[r] != '0);
   end

   for (genvar p = 0; p < NRD; p++) begin : g_port
      fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_mux (
         .rd_regf      (rd_regf[p*REG_W +: REG_W]),
         .from_ex_regf (from_ex_regf),
         .from_mm_regf (from_mm_regf),
         .from_wb_regf (from_wb_regf),
         .from_ex_data (from_ex_data),
         .from_mm_data (from_mm_data),
         .from_wb_data (from_wb_data),
         .fwd_valid    (fwd_valid[p]),
         .fwd_data     (fwd_data[p*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed and randomized bench for forward_scoreboard against a busy-cycle model.
module tb_forward_scoreboard;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int NRD    = 2;
   localparam int LAT_W  = 3;
   localparam int NREG   = 32;

   logic                  clk = 1'b0;
   logic                  rst, hold, flush, issue_valid, rd_jb;
   logic [REG_W-1:0]      issue_regf, from_ex_regf, from_mm_regf, from_wb_regf;
   logic [LAT_W-1:0]      issue_lat;
   logic [DATA_W-1:0]     from_ex_data, from_mm_data, from_wb_data;
   logic [NRD*REG_W-1:0]  rd_regf;
   logic [NRD-1:0]        fwd_valid;
   logic [NRD*DATA_W-1:0] fwd_data;
   logic                  stall;
   logic [NREG-1:0]       pending;

   int total = 0;
   int bad   = 0;
   int busy [NREG];
   logic last_stall;

   always #5 clk = ~clk;

   forward_scoreboard #(.DATA_W(DATA_W), .REG_W(REG_W), .NRD(NRD), .LAT_W(LAT_W)) dut (
      .clk(clk), .rst(rst), .hold(hold), .flush(flush),
      .issue_valid(issue_valid), .issue_regf(issue_regf), .issue_lat(issue_lat),
      .from_ex_regf(from_ex_regf), .from_mm_regf(from_mm_regf), .from_wb_regf(from_wb_regf),
      .from_ex_data(from_ex_data), .from_mm_data(from_mm_data), .from_wb_data(from_wb_data),
      .rd_regf(rd_regf), .rd_jb(rd_jb),
      .fwd_valid(fwd_valid), .fwd_data(fwd_data), .stall(stall), .pending(pending)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REG_W-1:0] src(int p);
      logic [NRD*REG_W-1:0] v;
      v = rd_regf;
      return v[p*REG_W +: REG_W];
   endfunction

   function automatic logic m_stall();
      logic s;
      s = 1'b0;
      for (int p = 0; p < NRD; p++) begin
         if (src(p) != 0 && busy[src(p)] > 0) s = 1'b1;
`ifdef FORWARD_SCOREBOARD_JB_EARLY_EN
         if (rd_jb && src(p) != 0 && (src(p) == from_ex_regf || src(p) == from_mm_regf)) s = 1'b1;
`endif
      end
      return s;
   endfunction

   // One clock of stimulus: check combinational outputs and state, advance the model, step the clock.
   task automatic cycle(string tag);
      logic [NRD-1:0]        ev;
      logic [NRD*DATA_W-1:0] ed;
      logic [NREG-1:0]       ep;
      logic                  es, acc;
      #1;
      es = m_stall();
      ev = '0;
      ed = '0;
      ep = '0;
      for (int p = 0; p < NRD; p++) begin
         if (src(p) == 0) ;
         else if (src(p) == from_ex_regf) begin ev[p] = 1'b1; ed[p*DATA_W +: DATA_W] = from_ex_data; end
         else if (src(p) == from_mm_regf) begin ev[p] = 1'b1; ed[p*DATA_W +: DATA_W] = from_mm_data; end
         else if (src(p) == from_wb_regf) begin ev[p] = 1'b1; ed[p*DATA_W +: DATA_W] = from_wb_data; end
      end
      for (int r = 1; r < NREG; r++) ep[r] = (busy[r] > 0);
      chk({tag, ".stall"}, 64'(stall), 64'(es));
      chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(ev));
      chk({tag, ".fwd_data"}, fwd_data, ed);
      chk({tag, ".pending"}, 64'(pending), 64'(ep));
      last_stall = stall;
      if (rst || flush) begin
         for (int r = 0; r < NREG; r++) busy[r] = 0;
      end else if (!hold) begin
         acc = issue_valid && !es && issue_regf != 0;
         for (int r = 1; r < NREG; r++) begin
            if (acc && r == int'(issue_regf)) busy[r] = int'(issue_lat);
            else if (busy[r] > 0) busy[r] = busy[r] - 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hold = 0; flush = 0; issue_valid = 0; issue_regf = 0; issue_lat = 0;
      from_ex_regf = 0; from_mm_regf = 0; from_wb_regf = 0;
      from_ex_data = 0; from_mm_data = 0; from_wb_data = 0;
      rd_regf = 0; rd_jb = 0;
   endtask

   initial begin
      int n;
      for (int r = 0; r < NREG; r++) busy[r] = 0;
      last_stall = 0;
      idle_inputs();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;

      // reset state, read r5 with idle buses
      rd_regf = {5'd0, 5'd5};
      #1;
      chk("reset.pending", 64'(pending), 64'd0);
      cycle("reset");

      // ALU r3 then EX forward
      issue_valid = 1; issue_regf = 3; issue_lat = 3'd0; rd_regf = 0;
      cycle("alu_issue");
      issue_valid = 0; from_ex_regf = 3; from_ex_data = 32'h1234; rd_regf = {5'd0, 5'd3};
      #1;
      chk("alu.fwd_data0", 64'(fwd_data[31:0]), 64'h1234);
      chk("alu.stall", 64'(stall), 64'd0);
      cycle("alu_fwd");

      // load r4 with a dependent behind it
      idle_inputs();
      issue_valid = 1; issue_regf = 4; issue_lat = 3'd1; rd_regf = {5'd4, 5'd0};
      cycle("load_issue");
      issue_valid = 0;
      #1;
      chk("load.stall_busy", 64'(stall), 64'd1);
      cycle("load_wait");
      from_mm_regf = 4; from_mm_data = 32'hBEEF;
      #1;
      chk("load.stall_done", 64'(stall), 64'd0);
      chk("load.fwd_valid1", 64'(fwd_valid[1]), 64'd1);
      chk("load.fwd_data1", 64'(fwd_data[63:32]), 64'hBEEF);
      cycle("load_fwd");

      // muldiv r7 lat 5 with two hold cycles mid-countdown
      idle_inputs();
      issue_valid = 1; issue_regf = 7; issue_lat = 3'd5;
      cycle("muldiv_issue");
      issue_valid = 0; rd_regf = {5'd0, 5'd7};
      n = 0;
      for (int k = 0; k < 20; k++) begin
         hold = (n == 1 || n == 2);
         cycle("muldiv");
         if (!last_stall) break;
         n++;
      end
      chk("muldiv.stall_cycles", 64'(n), 64'd7);

      // flush two cycles after issue, then issue+flush together
      idle_inputs();
      issue_valid = 1; issue_regf = 9; issue_lat = 3'd6;
      cycle("flush_issue");
      issue_valid = 0;
      cycle("flush_gap");
      flush = 1;
      cycle("flush");
      flush = 0; rd_regf = {5'd0, 5'd9};
      #1;
      chk("flush.pending9", 64'(pending[9]), 64'd0);
      chk("flush.stall", 64'(stall), 64'd0);
      cycle("flush_after");
      rd_regf = 0; issue_valid = 1; issue_regf = 9; issue_lat = 3'd6; flush = 1;
      cycle("flush_with_issue");
      idle_inputs();
      #1;
      chk("flush_issue.pending", 64'(pending), 64'd0);
      cycle("flush_issue_after");

      // branch in ID against an MM producer
      rd_jb = 1; rd_regf = {5'd0, 5'd2}; from_mm_regf = 2; from_mm_data = 32'hCAFE;
      #1;
`ifdef FORWARD_SCOREBOARD_JB_EARLY_EN
      chk("jb.stall", 64'(stall), 64'd1);
`else
      chk("jb.stall", 64'(stall), 64'd0);
`endif
      chk("jb.fwd_data0", 64'(fwd_data[31:0]), 64'hCAFE);
      cycle("jb");

      // reset while a dependent is stalled
      idle_inputs();
      issue_valid = 1; issue_regf = 6; issue_lat = 3'd7;
      cycle("rst_issue");
      issue_valid = 0; rd_regf = {5'd0, 5'd6};
      #1;
      chk("rst.stall_before", 64'(stall), 64'd1);
      rst = 1;
      cycle("rst_mid");
      rst = 0;
      #1;
      chk("rst.stall_after", 64'(stall), 64'd0);
      cycle("rst_after");

      // randomized traffic, register indices drawn from a small set to provoke hazards
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(99) < 2);
         flush        = ($urandom_range(99) < 5);
         hold         = ($urandom_range(99) < 10);
         issue_valid  = ($urandom_range(99) < 60);
         issue_regf   = REG_W'($urandom_range(7));
         issue_lat    = LAT_W'($urandom_range(7));
         from_ex_regf = ($urandom_range(3) == 0) ? 5'd0 : REG_W'($urandom_range(7));
         from_mm_regf = ($urandom_range(3) == 0) ? 5'd0 : REG_W'($urandom_range(7));
         from_wb_regf = ($urandom_range(3) == 0) ? 5'd0 : REG_W'($urandom_range(7));
         from_ex_data = $urandom;
         from_mm_data = $urandom;
         from_wb_data = $urandom;
         rd_regf      = {REG_W'($urandom_range(7)), REG_W'($urandom_range(7))};
         rd_jb        = ($urandom_range(3) == 0);
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised successor to the pipeline forwarding/hazard unit. It tracks every in-flight register write in a per-register latency scoreboard, so variable-latency producers are handled uniformly: ALU (0), load (1), and multi-cycle multiply/divide (up to 2^LAT_W-1). It gives NRD decode-stage read ports priority-forwarded data from the EX/MM/WB result buses, and raises a stall while any operand is still in flight. It sits beside the register file at the ID stage and is updated as each instruction issues from ID into EX.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register index width; scoreboard depth is 2^REG_W; register 0 is never tracked
- NRD, 2, number of ID read ports
- LAT_W, 3, latency counter width; maximum issue latency 2^LAT_W-1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  global pipeline freeze (e.g. memory wait); scoreboard frozen
- flush  in  1  squash all in-flight producers (exception/redirect)
- issue_valid  in  1  instruction leaves ID into EX this cycle
- issue_regf  in  REG_W  its destination register (0 = none)
- issue_lat  in  LAT_W  cycles after issue during which its result is on no bus
- from_ex_regf / from_mm_regf / from_wb_regf  in  REG_W  bus destinations (0 = invalid)
- from_ex_data / from_mm_data / from_wb_data  in  DATA_W  bus results
- rd_regf  in  NRD×REG_W  ID source registers
- rd_jb  in  1  ID instruction is a jump/branch resolved in ID
- fwd_valid  out  NRD  per-port forward hit
- fwd_data  out  NRD×DATA_W  per-port forwarded value (0 when no hit)
- stall  out  1  hold ID/IF, insert bubble into EX
- pending  out  2^REG_W  per-register "counter non-zero" vector, for debug

## Operation
- State: cnt[r] (LAT_W bits) for r = 1..2^REG_W-1. cnt[0] is hard-wired 0.
- Issue accepted when issue_valid & !stall & !hold & !flush & issue_regf != 0. On acceptance, cnt[issue_regf] <= issue_lat.
- Every cycle with !hold, every non-zero cnt decrements by 1. Issue to the same register overrides its decrement in that cycle.
- flush: all cnt <= 0. Takes priority over issue and hold.
- rst: all cnt <= 0. Takes priority over everything.
- Forward per port p, when rd_regf[p] != 0: EX bus match beats MM match, which beats WB match. Otherwise fwd_valid=0 and fwd_data=0.
- Stall sources, any of which sets stall:
  - some port p with rd_regf[p] != 0 and cnt[rd_regf[p]] != 0;
  - the optional branch rule under Configuration.
- When hold=1, stall is still computed, but no issue is accepted.
- issue_valid while stall=1 is ignored; the pipeline inserts a bubble.

## Timing
- fwd_valid, fwd_data and stall are combinational from the inputs and current cnt; zero cycles of latency.
- cnt updates on the clk edge; pending is registered state.
- Reset values: all cnt=0 and pending=0. With all regf inputs 0, stall=0, fwd_valid=0 and fwd_data=0.
- Load example (issue_lat=1): issue at edge t, so cnt=1 during cycle t+1 and a dependent in ID stalls 1 cycle. At edge t+2 cnt=0 and the value is forwarded from the MM bus.
- A latency-L producer stalls a dependent issued immediately behind it for exactly L cycles, plus any hold cycles.
- Simultaneous flush and issue: the scoreboard becomes all zero and the issue is lost.
- rst asserted mid-stall: stall drops the next cycle (bus inputs assumed 0).

## Configuration
- FORWARD_SCOREBOARD_JB_EARLY_EN defined: when rd_jb=1, a match of any rd_regf (≠0) against from_ex_regf or from_mm_regf also stalls. This keeps the EX/MM→ID compare path off branch resolution.
- Not defined: branches are treated as ordinary consumers and forward from EX/MM in the same cycle.
- Forwarding data paths are identical in both builds.

## Structure
- Shared package fwd_pkg holds:
  - lat_t (logic [LAT_W-1:0]) and regf_t;
  - the constant LAT_ALU=0, LAT_LOAD=1, LAT_MULDIV latencies used by decode;
  - NUM_REGS = 2^REG_W.
- One sub-module, fwd_mux: the three-source priority select for one read port, instantiated NRD times via generate.
- Scoreboard counters and stall reduction stay in the top module.

## Test plan
- Reset, then read r5 with all buses 0 -> stall=0, fwd_valid=0, pending=0.
- ALU issue r3 (lat 0); next cycle from_ex_regf=3, data 0x1234 with rd_regf[0]=3 -> fwd_valid[0]=1, fwd_data[0]=0x1234, stall=0.
- Load issue r4 (lat 1) with dependent rd_regf[1]=4 -> stall=1 for 1 cycle. Then with from_mm_regf=4, data 0xBEEF -> forward 0xBEEF, stall=0.
- Muldiv issue r7 (lat 5) with hold=1 for 2 cycles mid-countdown -> dependent stalls exactly 7 cycles.
- Issue r9 (lat 6), flush 2 cycles later -> pending[9]=0 next cycle and stall=0. Issue plus flush in the same cycle -> pending stays 0.
- rd_jb=1, rd_regf[0]=2, from_mm_regf=2 -> stall=1 with FORWARD_SCOREBOARD_JB_EARLY_EN. Without it, stall=0 and the MM data is forwarded.
